// File: rtl/t_ff.sv
// Toggle flip-flop bank with clock enable, synchronous parallel load
// and complemented output; each bit is independent.
module t_ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] t,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // en gates both load and toggle; load wins over toggle
    always_comb begin
        q_d = q_q;
        if (en) begin
            if (ld) begin
                q_d = d;
            end else begin
                q_d = q_q ^ t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_t_ff.sv
// Scoreboard bench for t_ff: a 1-bit default instance and a 4-bit
// instance with a non-zero reset value, directed plus random stimulus.
module tb_t_ff;

    logic       clk;
    logic       rst1, en1, ld1;
    logic [0:0] t1, d1, q1, qn1;
    logic       rst4, en4, ld4;
    logic [3:0] t4, d4, q4, qn4;

    localparam logic [3:0] RV4 = 4'b0110;

    t_ff u1 (
        .clk(clk), .rst(rst1), .en(en1), .t(t1),
        .ld(ld1), .d(d1), .q(q1), .qn(qn1)
    );

    t_ff #(.WIDTH(4), .RESET_VAL(RV4)) u4 (
        .clk(clk), .rst(rst4), .en(en4), .t(t4),
        .ld(ld4), .d(d4), .q(q4), .qn(qn4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       e1;
        logic [3:0] e4;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic       m1;
    logic [3:0] m4;

    // reference: reset, else enable, else load, else xor toggle
    function automatic logic [3:0] ref_next(
        input logic [3:0] cur, input logic [3:0] rv,
        input logic r, input logic e, input logic l,
        input logic [3:0] tv, input logic [3:0] dv);
        if (!r) return rv;
        if (!e) return cur;
        if (l) return dv;
        return cur ^ tv;
    endfunction

    task automatic step(
        input logic r1, input logic e1, input logic l1,
        input logic tt1, input logic dd1,
        input logic r4, input logic e4, input logic l4,
        input logic [3:0] tt4, input logic [3:0] dd4,
        input string nm);
        exp_t x;
        logic [3:0] n1;
        @(negedge clk);
        rst1 = r1; en1 = e1; ld1 = l1; t1 = tt1; d1 = dd1;
        rst4 = r4; en4 = e4; ld4 = l4; t4 = tt4; d4 = dd4;
        n1 = ref_next({3'b0, m1}, 4'b0, r1, e1, l1,
                      {3'b0, tt1}, {3'b0, dd1});
        m1 = n1[0];
        m4 = ref_next(m4, RV4, r4, e4, l4, tt4, dd4);
        x.e1 = m1;
        x.e4 = m4;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic cmp(input string nm, input logic [3:0] act,
                       input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                cmp({x.name, " q1"},  {3'b0, q1},  {3'b0, x.e1});
                cmp({x.name, " qn1"}, {3'b0, qn1}, {3'b0, ~x.e1});
                cmp({x.name, " q4"},  q4,  x.e4);
                cmp({x.name, " qn4"}, qn4, ~x.e4);
            end
        end
    end

    initial begin : stim
        int wait_cyc;
        logic r;
        m1 = 1'b0;
        m4 = 4'b0;
        // reset: u1 with t=1 en=1, u4 with en=0
        step(0,1,0,1,0, 0,0,0,4'hF,4'h0, "reset_a");
        step(0,1,0,1,0, 0,0,0,4'hF,4'h0, "reset_b");
        // u1 toggles; u4 loads 0000 then 1010 over t, then toggles
        step(1,1,0,1,0, 1,1,1,4'h0,4'h0, "tog1");
        step(1,1,0,1,0, 1,1,1,4'hF,4'hA, "tog2_ld");
        step(1,1,0,1,0, 1,1,0,4'h3,4'hF, "tog3_t");
        step(1,1,0,1,0, 1,0,1,4'hF,4'h5, "tog4_noen");
        step(1,1,0,1,0, 1,1,0,4'hF,4'h0, "tog5");
        // u1 holds at 1
        step(1,1,0,0,0, 1,0,0,4'hF,4'h0, "hold_t0a");
        step(1,1,0,0,0, 1,0,0,4'hF,4'h0, "hold_t0b");
        step(1,1,0,0,0, 1,0,0,4'hF,4'h0, "hold_t0c");
        step(1,0,0,1,0, 1,0,0,4'hF,4'h0, "hold_en0a");
        step(1,0,0,1,0, 1,0,0,4'hF,4'h0, "hold_en0b");
        step(1,0,1,1,0, 1,0,0,4'hF,4'h0, "hold_ld_en0");
        // mid-run reset while q1=1, then resume; u4 reset with en=0
        step(0,1,0,1,0, 0,0,1,4'hF,4'hF, "midrst");
        step(1,1,0,1,0, 1,1,0,4'h1,4'h0, "resume");
        step(1,1,0,1,0, 1,1,0,4'h8,4'h0, "resume2");
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) != 0);
            step(r, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 15) != 0),
                 1'($urandom), ($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom), "rand");
        end
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
